// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: deglitched framing, E0/F0 prefix tracking
// and held/released levels for a small table of keys.
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int NUM_KEYS    = 2,
    parameter logic [9*NUM_KEYS-1:0] KEY_CODES = {9'h172, 9'h175}
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                ps2_clk_in,
    input  logic                ps2_dat_in,
    output logic [7:0]          code_out,
    output logic                code_valid,
    output logic                code_ext,
    output logic                code_break,
    output logic                frame_err,
    output logic [7:0]          last_byte,
    output logic [NUM_KEYS-1:0] key_held
);
    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic [FW-1:0] flt_cnt_q;
    logic          flt_q, flt_prev_q;
    logic          fall, dat;

    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] to_q;
    logic          acc_q, err_q;

    logic          ext_q, brk_q;
    logic [7:0]    code_q, last_q;
    logic          valid_q, cext_q, cbrk_q, ferr_q;
    logic [NUM_KEYS-1:0] held_q;

    assign fall = flt_prev_q & ~flt_q;
    assign dat  = dat_sync_q[1];

    // Filtered clock follows the synchroniser only after a stable run.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            flt_cnt_q  <= '0;
            flt_q      <= 1'b1;
            flt_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
            flt_prev_q <= flt_q;
            if (clk_sync_q[1] != flt_q) begin
                if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                    flt_q     <= clk_sync_q[1];
                    flt_cnt_q <= '0;
                end else begin
                    flt_cnt_q <= flt_cnt_q + 1'b1;
                end
            end else begin
                flt_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            to_q      <= '0;
            acc_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            acc_q <= 1'b0;
            err_q <= 1'b0;
            if (state_q == IDLE || fall) to_q <= '0;
            else                         to_q <= to_q + 1'b1;
            unique case (state_q)
                IDLE: if (fall && !dat) begin
                    state_q   <= DATA;
                    bit_cnt_q <= '0;
                end
                DATA: if (fall) begin
                    shift_q   <= {dat, shift_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_q <= PARITY;
                end
                PARITY: if (fall) begin
                    par_q   <= dat;
                    state_q <= STOP;
                end
                STOP: if (fall) begin
                    if (dat && (^{shift_q, par_q})) acc_q <= 1'b1;
                    else                            err_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
            if (state_q != IDLE && !fall && to_q == TW'(TIMEOUT_CYC)) begin
                err_q   <= 1'b1;
                state_q <= IDLE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            code_q  <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            cext_q  <= 1'b0;
            cbrk_q  <= 1'b0;
            ferr_q  <= 1'b0;
            held_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= err_q;
            if (err_q) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (acc_q) begin
                last_q <= shift_q;
                if (shift_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    code_q  <= shift_q;
                    cext_q  <= ext_q;
                    cbrk_q  <= brk_q;
                    valid_q <= 1'b1;
                    ext_q   <= 1'b0;
                    brk_q   <= 1'b0;
                    for (int i = 0; i < NUM_KEYS; i++) begin
                        if (KEY_CODES[9*i +: 9] == {ext_q, shift_q})
                            held_q[i] <= ~brk_q;
                    end
                end
            end
        end
    end

    assign code_out   = code_q;
    assign code_valid = valid_q;
    assign code_ext   = cext_q;
    assign code_break = cbrk_q;
    assign frame_err  = ferr_q;
    assign last_byte  = last_q;
    assign key_held   = held_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: frames driven bit by bit on a
// slow PS/2 clock, strobes counted and latched by a monitor.
module tb_ps2_key_decoder;
    localparam int FL = 8;
    localparam int TO = 300;
    localparam int H  = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic [7:0] code_out, last_byte;
    logic       code_valid, code_ext, code_break, frame_err;
    logic [1:0] key_held;

    int nvec = 0;
    int nmis = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int nvalid = 0;
    int nerr = 0;
    int vcyc = 0;
    int ecyc = 0;

    ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clock(clk), .reset_n(rst_n),
        .ps2_clk_in(ps2c), .ps2_dat_in(ps2d),
        .code_out(code_out), .code_valid(code_valid),
        .code_ext(code_ext), .code_break(code_break),
        .frame_err(frame_err), .last_byte(last_byte),
        .key_held(key_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (code_valid) begin
            nvalid = nvalid + 1;
            vcyc = cyc;
        end
        if (frame_err) begin
            nerr = nerr + 1;
            ecyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b,
                                       input logic badpar,
                                       input logic stop);
        return {stop, (~^b) ^ badpar, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] fr, input int n,
                             input int glitch_at);
        for (int i = 0; i < n; i++) begin
            ps2d = fr[i];
            wait_cyc(H);
            ps2c = 1'b0;
            if (i == 10) fall_cyc = cyc;
            wait_cyc(H);
            ps2c = 1'b1;
            if (i == glitch_at) begin
                wait_cyc(H / 2);
                ps2c = 1'b0;
                wait_cyc(3);
                ps2c = 1'b1;
                wait_cyc(H / 2);
            end
        end
        ps2d = 1'b1;
        wait_cyc(H);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(mk(b, 1'b0, 1'b1), 11, -1);
    endtask

    task automatic clr();
        nvalid = 0;
        nerr = 0;
    endtask

    initial begin
        wait_cyc(3);
        chk("rst_code", code_out, 8'h00);
        chk("rst_valid", code_valid, 1'b0);
        chk("rst_last", last_byte, 8'h00);
        chk("rst_held", key_held, 2'b00);
        chk("rst_ferr", frame_err, 1'b0);
        rst_n = 1'b1;
        wait_cyc(20);

        clr();
        send(8'h1C);
        chk("good_nvalid", nvalid, 1);
        chk("good_code", code_out, 8'h1C);
        chk("good_ext", code_ext, 1'b0);
        chk("good_brk", code_break, 1'b0);
        chk("good_last", last_byte, 8'h1C);
        chk("good_nerr", nerr, 0);
        chk("good_held", key_held, 2'b00);
        chk("good_lat", vcyc - fall_cyc, FL + 4);

        clr();
        send(8'hE0);
        send(8'h75);
        chk("up_nvalid", nvalid, 1);
        chk("up_code", code_out, 8'h75);
        chk("up_ext", code_ext, 1'b1);
        chk("up_held", key_held, 2'b01);

        clr();
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk("upbrk_nvalid", nvalid, 1);
        chk("upbrk_brk", code_break, 1'b1);
        chk("upbrk_ext", code_ext, 1'b1);
        chk("upbrk_held", key_held, 2'b00);

        send(8'hE0);
        send(8'h72);
        chk("dn_held", key_held, 2'b10);
        chk("dn_brk", code_break, 1'b0);

        clr();
        send_bits(mk(8'h1C, 1'b1, 1'b1), 11, -1);
        chk("par_nerr", nerr, 1);
        chk("par_nvalid", nvalid, 0);
        chk("par_lat", ecyc - fall_cyc, FL + 4);
        chk("par_last", last_byte, 8'h72);
        send(8'h29);
        chk("par_next_code", code_out, 8'h29);
        chk("par_next_ext", code_ext, 1'b0);

        clr();
        send(8'hE0);
        send_bits(mk(8'h75, 1'b0, 1'b0), 11, -1);
        chk("stop_nerr", nerr, 1);
        chk("stop_held", key_held, 2'b10);
        send(8'h75);
        chk("stop_next_ext", code_ext, 1'b0);
        chk("stop_next_code", code_out, 8'h75);
        chk("stop_next_held", key_held, 2'b10);

        clr();
        send_bits(mk(8'h33, 1'b0, 1'b1), 5, -1);
        wait_cyc(TO + 10 + FL + 4);
        chk("to_nerr", nerr, 1);
        chk("to_nvalid", nvalid, 0);
        send(8'h29);
        chk("to_next_code", code_out, 8'h29);
        chk("to_next_nvalid", nvalid, 1);

        clr();
        send_bits(mk(8'h5A, 1'b0, 1'b1), 11, 4);
        chk("gl_code", code_out, 8'h5A);
        chk("gl_nvalid", nvalid, 1);
        chk("gl_nerr", nerr, 0);

        send_bits(mk(8'h4B, 1'b0, 1'b1), 6, -1);
        rst_n = 1'b0;
        #1;
        chk("mrst_code", code_out, 8'h00);
        chk("mrst_held", key_held, 2'b00);
        chk("mrst_last", last_byte, 8'h00);
        chk("mrst_ext", code_ext, 1'b0);
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(20);
        clr();
        send(8'h1C);
        chk("mrst_next_code", code_out, 8'h1C);
        chk("mrst_next_nvalid", nvalid, 1);
        chk("mrst_next_nerr", nerr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
